// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light blocks.
package f1_pkg;
    localparam int LFSR_W    = 7;
    localparam int LFSR_TAPA = 6;
    localparam int LFSR_TAPB = 2;
    localparam int DELAY_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } delay_state_e;

    // Light-bar state used by the upstream sequencer.
    typedef enum logic [2:0] {
        LIGHTS_OFF = 3'd0,
        LIGHTS_1   = 3'd1,
        LIGHTS_2   = 3'd2,
        LIGHTS_3   = 3'd3,
        LIGHTS_4   = 3'd4,
        LIGHTS_5   = 3'd5,
        LIGHTS_OUT = 3'd6
    } light_state_e;
endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR, x^7+x^3+1, period 127.
module f1_lfsr7
    import f1_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAPA] ^ lfsr_q[LFSR_TAPB]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;
endmodule

// File: rtl/f1_random_delay.sv
// Random hold between lights-on and lights-out: captures the LFSR at trigger,
// counts that many timebase ticks, then pulses time_out for one cycle.
module f1_random_delay
    import f1_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01,
    parameter int unsigned       MIN_DELAY = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               trigger,
    input  logic               abort,
    output logic               time_out,
    output logic               busy,
    output logic [DELAY_W-1:0] delay_len,
    output logic [LFSR_W-1:0]  lfsr_out
);
    logic [LFSR_W-1:0]  lfsr_val;
    delay_state_e       state_q, state_d;
    logic [DELAY_W-1:0] count_q, count_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               time_out_q, time_out_d;
    logic               busy_q, busy_d;

    f1_lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        delay_d = delay_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = LOAD;
                    delay_d = {1'b0, lfsr_val} + DELAY_W'(MIN_DELAY);
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    count_d = delay_q;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Abort wins over a tick that would finish the count.
                if (abort)                        state_d = IDLE;
                else if (en && count_q == 8'd1)   state_d = DONE;
                else if (en)                      count_d = count_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign time_out_d = (state_d == DONE);
    assign busy_d     = (state_d == LOAD) || (state_d == COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            delay_q    <= '0;
            time_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
            time_out_q <= time_out_d;
            busy_q     <= busy_d;
        end
    end

    assign time_out  = time_out_q;
    assign busy      = busy_q;
    assign delay_len = delay_q;
    assign lfsr_out  = lfsr_val;
endmodule

// File: tb/tb_f1_random_delay.sv
// Directed bench for f1_random_delay: one instance with MIN_DELAY=0, one with 10.
module tb_f1_random_delay;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0, trig0 = 1'b0, abort0 = 1'b0;
    logic       en1 = 1'b0, trig1 = 1'b0, abort1 = 1'b0;
    logic       to0, busy0, to1, busy1;
    logic [7:0] dl0, dl1;
    logic [6:0] lf0, lf1;
    int         checks = 0;
    int         failures = 0;
    int         pulses;

    always #5 clk = ~clk;

    f1_random_delay #(.LFSR_SEED(7'h01), .MIN_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .trigger(trig0), .abort(abort0),
        .time_out(to0), .busy(busy0), .delay_len(dl0), .lfsr_out(lf0)
    );

    f1_random_delay #(.LFSR_SEED(7'h01), .MIN_DELAY(10)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .trigger(trig1), .abort(abort1),
        .time_out(to1), .busy(busy1), .delay_len(dl1), .lfsr_out(lf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [8];
        seq = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h24, 8'h49, 8'h13};

        // Reset state and LFSR sequence
        do_reset();
        chk("rst_time_out", to0, 8'd0);
        chk("rst_busy", busy0, 8'd0);
        chk("rst_delay_len", dl0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lfsr_seq%0d", i), lf0, seq[i]);
            step();
        end

        // en constant, trigger at lfsr=04 -> delay 4, time_out 6 cycles later
        do_reset();
        step();
        step();
        en0 = 1'b1; trig0 = 1'b1;
        chk("t2_lfsr_at_trig", lf0, 8'h04);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            trig0 = 1'b0;
            if (k == 1) begin
                chk("t2_busy_load", busy0, 8'd1);
                chk("t2_delay_len", dl0, 8'd4);
            end
            if (k == 5) chk("t2_no_early_pulse", to0, 8'd0);
            if (k == 6) chk("t2_time_out", to0, 8'd1);
            if (k == 7) begin
                chk("t2_time_out_end", to0, 8'd0);
                chk("t2_busy_end", busy0, 8'd0);
            end
            if (to0) pulses++;
        end
        chk("t2_pulse_count", 8'(pulses), 8'd1);
        en0 = 1'b0;

        // MIN_DELAY=10, en every third cycle, trigger at lfsr=09 -> 19
        do_reset();
        step();
        step();
        step();
        trig1 = 1'b1;
        chk("t3_lfsr_at_trig", lf1, 8'h09);
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            trig1 = 1'b0;
            en1 = (k % 3 == 0);
            if (k == 1) chk("t3_delay_len", dl1, 8'd19);
            if (k < 58 && to1) pulses++;
            if (k == 58) chk("t3_time_out", to1, 8'd1);
            if (k == 59) chk("t3_time_out_end", to1, 8'd0);
        end
        chk("t3_early_pulses", 8'(pulses), 8'd0);
        en1 = 1'b0;

        // Retrigger mid-COUNT ignored; fresh capture afterwards; abort at count==1
        do_reset();
        step();
        step();
        en0 = 1'b1; trig0 = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            trig0 = (k == 3) || (k == 8);
            abort0 = (k == 35);
            if (k == 4) chk("t4_delay_kept", dl0, 8'd4);
            if (k == 6) chk("t4_time_out", to0, 8'd1);
            if (k == 8) chk("t4_lfsr_retrig", lf0, 8'h1A);
            if (k == 9) chk("t4_new_delay", dl0, 8'h1A);
            if (k == 36) begin
                chk("t5_abort_no_pulse", to0, 8'd0);
                chk("t5_abort_idle", busy0, 8'd0);
                chk("t5_delay_retained", dl0, 8'h1A);
            end
            if (to0) pulses++;
        end
        chk("t4_total_pulses", 8'(pulses), 8'd1);
        abort0 = 1'b0;

        // Asynchronous reset in the middle of a countdown
        trig0 = 1'b1;
        step();
        trig0 = 1'b0;
        step();
        step();
        chk("t6_busy_before_rst", busy0, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy0, 8'd0);
        chk("t6_rst_time_out", to0, 8'd0);
        chk("t6_rst_delay_len", dl0, 8'd0);
        chk("t6_rst_lfsr", lf0, 8'h01);
        step();
        rst = 1'b0;
        chk("t6_lfsr_release", lf0, 8'h01);
        step();
        chk("t6_lfsr_next", lf0, 8'h02);
        en0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/f1_random_delay.md
Name: f1_random_delay

Overview:
- Downstream of the F1 start-light sequencer; consumes its `cmd_delay` pulse, which it raises when the light bar reaches all-on.
- Runs a free-running 7-bit LFSR and captures its value at trigger as a random hold time.
- Counts that many timebase ticks, then emits a one-cycle `time_out` pulse that tells the sequencer and the reaction timer the lights are out.
- One clock domain.

Parameters:
- LFSR_SEED, 7'h01, LFSR value after reset. Must be nonzero.
- MIN_DELAY, 0, ticks added to the captured LFSR value. Range 0..127.

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- rst  input  1  reset, asynchronous, active-high
- en  input  1  timebase tick, one-cycle strobe; the countdown advances only when en=1
- trigger  input  1  start request (sequencer cmd_delay); sampled on clk
- abort  input  1  synchronous cancel of a running countdown
- time_out  output  1  one-cycle pulse when the countdown completes
- busy  output  1  high while in LOAD or COUNT
- delay_len  output  8  hold length captured at the last trigger (LFSR + MIN_DELAY)
- lfsr_out  output  7  current LFSR value, for display/debug

Behaviour:
- Reset (asynchronous, rst=1):
  - lfsr=LFSR_SEED, state=IDLE, count=0, delay_len=0, time_out=0, busy=0.
- LFSR:
  - Fibonacci form, polynomial x^7+x^3+1.
  - Every clk edge (regardless of en or state): lfsr <= {lfsr[5:0], lfsr[6]^lfsr[2]}.
  - Period 127; the value 0 is never reached.
  - From seed 7'h01 the sequence is 01,02,04,09,12,24,49,13,...
- State machine (IDLE, LOAD, COUNT, DONE):
  - IDLE: trigger=1 -> LOAD. On that edge, delay_len <= {1'b0,lfsr} + MIN_DELAY, where lfsr is the value present in the trigger cycle. Width is 8 bits; no overflow is possible (max 254).
  - LOAD: count <= delay_len -> COUNT. busy=1. This state exists so the capture is isolated from a same-cycle en.
  - COUNT:
    - en=1 and count>1: count <= count-1.
    - en=1 and count==1: -> DONE.
    - en=0: hold.
  - DONE: time_out=1 for exactly this one cycle -> IDLE.
- Latency:
  - With en held at 1, time_out asserts 2+delay_len cycles after the trigger cycle.
  - In general it asserts the cycle after the delay_len-th en strobe counted in COUNT.
- Output timing:
  - time_out and busy are registered (Moore) outputs; no combinational path from any input to any output.
- Boundary conditions:
  - trigger in LOAD, COUNT or DONE: ignored. No restart, no re-capture, delay_len unchanged.
  - trigger held high: only its first cycle in IDLE matters. After DONE->IDLE, a still-high trigger starts a new run (level-sampled in IDLE).
  - abort=1 in LOAD or COUNT: -> IDLE next edge, no time_out, delay_len retained. Abort has priority over a same-cycle count reaching terminal.
  - abort=1 in IDLE or DONE: no effect. The DONE pulse still completes.
  - rst mid-countdown: immediate return to the reset values above, no time_out; the LFSR restarts from the seed.
  - delay_len cannot be 0, because the LFSR is never 0.

Decomposition:
- Shared package f1_pkg:
  - state enum typedef (IDLE, LOAD, COUNT, DONE);
  - LFSR width constant 7;
  - tap positions 6 and 2;
  - delay width constant 8.
  - The sequencer's light-state typedef also moves here.
- One sub-module: f1_lfsr7 (clk, rst, seed parameter, 7-bit q). The FSM and counter stay in the top.

Test Plan:
- Reset release with LFSR_SEED=7'h01 -> lfsr_out reads 01,02,04,09,12,24,49,13 on consecutive cycles; time_out=0, busy=0, delay_len=0.
- en=1 constantly; trigger one cycle while lfsr_out=7'h04 -> delay_len=8'd4, busy rises next cycle, time_out high exactly 6 cycles after the trigger cycle for one cycle, then busy=0.
- MIN_DELAY=10; en strobed once every 3 cycles; trigger at lfsr_out=7'h09 -> delay_len=19; time_out the cycle after the 19th en seen in COUNT.
- Second trigger pulse mid-COUNT -> ignored: delay_len unchanged, single time_out at the original time. After return to IDLE, a new trigger captures a fresh LFSR value.
- abort during COUNT with count==1 and en=1 in the same cycle -> IDLE, no time_out pulse; rst asserted mid-COUNT -> all outputs zero immediately (asynchronous), lfsr_out=01 after release.
